// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared glyph constants, digit type, FSM state enum and the
//                BCD-to-binary helper for the three-digit segment reader.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [0:0] {
        EMPTY  = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Active-low glyphs, bit order g..a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // d2*100 + d1*10 + d0 built from shifted terms (100 = 64+32+4, 10 = 8+2)
    function automatic logic [9:0] bcd3_to_bin(input digit_t d2, input digit_t d1,
                                               input digit_t d0);
        logic [9:0] h;
        logic [9:0] t;
        logic [9:0] u;
        h = {6'd0, d2};
        t = {6'd0, d1};
        u = {6'd0, d0};
        return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_reader_3dig_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_reader_3dig_if
//  Description : Segment-bus sampling inputs and decoded result outputs of
//                the three-digit reader, grouped for connection.
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_reader_3dig_if;
    import seg7_pkg::*;

    logic       sample_en;
    logic [6:0] seg2;
    logic [6:0] seg1;
    logic [6:0] seg0;
    logic       clear;
    digit_t     bcd2;
    digit_t     bcd1;
    digit_t     bcd0;
    logic [9:0] value;
    logic       valid;
    logic       upd;
    logic       bad_pat;
    logic       step_err;
    logic       err_bad;
    logic       err_step;
    logic [7:0] upd_cnt;

    modport master (
        output sample_en, seg2, seg1, seg0, clear,
        input  bcd2, bcd1, bcd0, value, valid, upd, bad_pat, step_err,
               err_bad, err_step, upd_cnt
    );

    modport slave (
        input  sample_en, seg2, seg1, seg0, clear,
        output bcd2, bcd1, bcd0, value, valid, upd, bad_pat, step_err,
               err_bad, err_step, upd_cnt
    );

endinterface
`default_nettype wire

// File: rtl/seg7_dec.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_dec
//  Description : Combinational active-low glyph to BCD decoder with a legal
//                flag; any code outside the ten digit glyphs is illegal.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_dec
    import seg7_pkg::*;
(
    input  wire logic [6:0] seg,
    output digit_t          bcd,
    output logic            legal
);

    // Table lookup; illegal codes report digit 0 with legal low
    always_comb begin
        bcd   = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_reader_3dig.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_reader_3dig
//  Description : Samples three active-low glyph buses, debounces the combined
//                pattern, decodes it to BCD/binary and flags illegal glyphs
//                and count-sequence violations (wrap after MAX_VALUE).
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_reader_3dig
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_N  = 2,
    parameter int unsigned MAX_VALUE = 999
) (
    input  wire logic         clk,
    input  wire logic         rst,
    seg7_reader_3dig_if.slave bus
);

    localparam logic [3:0] c_stab_n    = 4'(STABLE_N);
    localparam logic [9:0] c_max_value = 10'(MAX_VALUE);

    logic [20:0] w_smp;
    logic [6:0]  w_seg [3];
    digit_t      w_dig [3];
    logic        w_legal [3];
    logic        w_all_legal;
    logic [9:0]  w_new_val;
    logic [9:0]  w_expected;

    logic [20:0] r_last_smp, w_last_smp_n;
    logic        r_last_ld,  w_last_ld_n;
    logic [3:0]  r_stab_cnt, w_stab_n;
    logic [20:0] r_acc_pat;
    logic        r_acc_ld;
    logic        w_accept;

    state_t      r_state, w_state_n;
    digit_t      r_bcd2, r_bcd1, r_bcd0, w_bcd2_n, w_bcd1_n, w_bcd0_n;
    logic [9:0]  r_value, w_value_n;
    logic        r_valid, w_valid_n;
    logic        r_upd, w_upd_n;
    logic        r_bad, w_bad_n;
    logic        r_step, w_step_n;
    logic        r_err_bad, w_err_bad_n;
    logic        r_err_step, w_err_step_n;
    logic [7:0]  r_upd_cnt, w_upd_cnt_n;

    assign w_smp    = {bus.seg2, bus.seg1, bus.seg0};
    assign w_seg[2] = bus.seg2;
    assign w_seg[1] = bus.seg1;
    assign w_seg[0] = bus.seg0;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_dec
            seg7_dec u_dec (
                .seg   (w_seg[i]),
                .bcd   (w_dig[i]),
                .legal (w_legal[i])
            );
        end
    endgenerate

    assign w_all_legal = w_legal[2] & w_legal[1] & w_legal[0];
    assign w_new_val   = bcd3_to_bin(w_dig[2], w_dig[1], w_dig[0]);
    assign w_expected  = (r_value == c_max_value) ? 10'd0 : r_value + 10'd1;

    // Stability filter: count identical samples, accept a new pattern once
    always_comb begin
        w_last_smp_n = r_last_smp;
        w_last_ld_n  = r_last_ld;
        w_stab_n     = r_stab_cnt;
        w_accept     = 1'b0;
        if (bus.sample_en) begin
            if (r_last_ld && (w_smp == r_last_smp)) begin
                if (r_stab_cnt != c_stab_n) begin
                    w_stab_n = r_stab_cnt + 4'd1;
                end
            end else begin
                w_last_smp_n = w_smp;
                w_last_ld_n  = 1'b1;
                w_stab_n     = 4'd1;
            end
            w_accept = (w_stab_n == c_stab_n) && (!r_acc_ld || (w_smp != r_acc_pat));
        end
    end

    // Filter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_smp <= '0;
            r_last_ld  <= 1'b0;
            r_stab_cnt <= '0;
            r_acc_pat  <= '0;
            r_acc_ld   <= 1'b0;
        end else begin
            r_last_smp <= w_last_smp_n;
            r_last_ld  <= w_last_ld_n;
            r_stab_cnt <= w_stab_n;
            if (w_accept) begin
                r_acc_pat <= w_smp;
                r_acc_ld  <= 1'b1;
            end
        end
    end

    // Next state, decoded digits, pulses, sticky flags and update counter
    always_comb begin
        w_state_n = r_state;
        w_bcd2_n  = r_bcd2;
        w_bcd1_n  = r_bcd1;
        w_bcd0_n  = r_bcd0;
        w_value_n = r_value;
        w_valid_n = r_valid;
        w_upd_n   = 1'b0;
        w_bad_n   = 1'b0;
        w_step_n  = 1'b0;
        if (w_accept) begin
            if (!w_all_legal) begin
                w_bad_n = 1'b1;
            end else begin
                w_bcd2_n  = w_dig[2];
                w_bcd1_n  = w_dig[1];
                w_bcd0_n  = w_dig[0];
                w_value_n = w_new_val;
                w_valid_n = 1'b1;
                w_upd_n   = 1'b1;
                w_state_n = LOCKED;
                // Values past MAX_VALUE can never be a legal successor
                if ((r_state == LOCKED) &&
                    ((w_new_val != w_expected) || (w_new_val > c_max_value))) begin
                    w_step_n = 1'b1;
                end
            end
        end
        // A same-cycle event overrides clear
        w_err_bad_n  = (bus.clear ? 1'b0 : r_err_bad)  | w_bad_n;
        w_err_step_n = (bus.clear ? 1'b0 : r_err_step) | w_step_n;
        if (bus.clear) begin
            w_upd_cnt_n = {7'd0, w_upd_n};
        end else if (w_upd_n && (r_upd_cnt != 8'hFF)) begin
            w_upd_cnt_n = r_upd_cnt + 8'd1;
        end else begin
            w_upd_cnt_n = r_upd_cnt;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= EMPTY;
            r_bcd2     <= '0;
            r_bcd1     <= '0;
            r_bcd0     <= '0;
            r_value    <= '0;
            r_valid    <= 1'b0;
            r_upd      <= 1'b0;
            r_bad      <= 1'b0;
            r_step     <= 1'b0;
            r_err_bad  <= 1'b0;
            r_err_step <= 1'b0;
            r_upd_cnt  <= '0;
        end else begin
            r_state    <= w_state_n;
            r_bcd2     <= w_bcd2_n;
            r_bcd1     <= w_bcd1_n;
            r_bcd0     <= w_bcd0_n;
            r_value    <= w_value_n;
            r_valid    <= w_valid_n;
            r_upd      <= w_upd_n;
            r_bad      <= w_bad_n;
            r_step     <= w_step_n;
            r_err_bad  <= w_err_bad_n;
            r_err_step <= w_err_step_n;
            r_upd_cnt  <= w_upd_cnt_n;
        end
    end

    assign bus.bcd2     = r_bcd2;
    assign bus.bcd1     = r_bcd1;
    assign bus.bcd0     = r_bcd0;
    assign bus.value    = r_value;
    assign bus.valid    = r_valid;
    assign bus.upd      = r_upd;
    assign bus.bad_pat  = r_bad;
    assign bus.step_err = r_step;
    assign bus.err_bad  = r_err_bad;
    assign bus.err_step = r_err_step;
    assign bus.upd_cnt  = r_upd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seg7_reader_3dig.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_reader_3dig
//  Description : Directed self-checking bench for seg7_reader_3dig
//                (STABLE_N=2, MAX_VALUE=999).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_reader_3dig;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_upd;
    int   n_bad;
    int   n_step;

    seg7_reader_3dig_if bus ();

    seg7_reader_3dig #(
        .STABLE_N  (2),
        .MAX_VALUE (999)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-owned glyph table, active-low g..a
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] pat(input int v);
        return {glyph((v / 100) % 10), glyph((v / 10) % 10), glyph(v % 10)};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one pattern for n sample cycles; clear rides on the last cycle
    task automatic drive(input logic [20:0] p, input int n, input logic clr_last);
        n_upd  = 0;
        n_bad  = 0;
        n_step = 0;
        for (int i = 0; i < n; i++) begin
            {bus.seg2, bus.seg1, bus.seg0} = p;
            bus.sample_en = 1'b1;
            bus.clear     = clr_last && (i == n - 1);
            @(posedge clk);
            #1;
            n_upd  += int'(bus.upd);
            n_bad  += int'(bus.bad_pat);
            n_step += int'(bus.step_err);
        end
        bus.sample_en = 1'b0;
        bus.clear     = 1'b0;
    endtask

    task automatic idle(input logic clr);
        bus.sample_en = 1'b0;
        bus.clear     = clr;
        @(posedge clk);
        #1;
        bus.clear     = 1'b0;
    endtask

    initial begin
        int tot_upd;
        int tot_step;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.sample_en = 1'b0;
        bus.clear     = 1'b0;
        {bus.seg2, bus.seg1, bus.seg0} = pat(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_value", int'(bus.value), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_bcd", int'({bus.bcd2, bus.bcd1, bus.bcd0}), 0);
        check("rst_flags", int'({bus.upd, bus.bad_pat, bus.step_err, bus.err_bad, bus.err_step}), 0);
        check("rst_upd_cnt", int'(bus.upd_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 000 latency: first sample loads the filter, second accepts
        drive(pat(0), 1, 1'b0);
        check("lat_first_upd", int'(bus.upd), 0);
        drive(pat(0), 1, 1'b0);
        check("lat_second_upd", int'(bus.upd), 1);
        check("v000_valid", int'(bus.valid), 1);
        drive(pat(0), 1, 1'b0);
        check("hold_no_reaccept", int'(bus.upd), 0);
        drive(pat(1), 3, 1'b0);
        check("v001_upd", n_upd, 1);
        check("v001_value", int'(bus.value), 1);
        drive(pat(2), 3, 1'b0);
        check("v002_upd", n_upd, 1);
        check("v002_bcd", int'({bus.bcd2, bus.bcd1, bus.bcd0}), 12'h002);
        check("seq_upd_cnt", int'(bus.upd_cnt), 3);
        check("seq_err_step", int'(bus.err_step), 0);

        // 002 -> 999 is a jump; then clear, wrap to 000, then bad jump to 005
        drive(pat(999), 2, 1'b0);
        check("jump999_step", n_step, 1);
        check("v999_bcd", int'({bus.bcd2, bus.bcd1, bus.bcd0}), 12'h999);
        idle(1'b1);
        check("clear_err_step", int'(bus.err_step), 0);
        check("clear_upd_cnt", int'(bus.upd_cnt), 0);
        check("idle_pulse_low", int'(bus.upd), 0);
        drive(pat(0), 2, 1'b0);
        check("wrap_step", n_step, 0);
        check("wrap_value", int'(bus.value), 0);
        drive(pat(5), 2, 1'b0);
        check("v005_step", n_step, 1);
        check("v005_err_step", int'(bus.err_step), 1);
        check("v005_value", int'(bus.value), 5);

        // Illegal units glyph while locked at 7
        drive(pat(6), 2, 1'b0);
        drive(pat(7), 2, 1'b0);
        check("v007_step", n_step, 0);
        drive({glyph(0), glyph(0), 7'b1111111}, 2, 1'b0);
        check("blank_bad", n_bad, 1);
        check("blank_upd", n_upd, 0);
        check("blank_err_bad", int'(bus.err_bad), 1);
        check("blank_value", int'(bus.value), 7);
        drive(pat(8), 2, 1'b0);
        check("v008_step", n_step, 0);
        check("v008_value", int'(bus.value), 8);

        // Glitch rejection
        drive(pat(3), 2, 1'b0);
        drive(pat(4), 1, 1'b0);
        drive(pat(3), 2, 1'b0);
        check("glitch_no_upd", n_upd, 0);
        drive(pat(4), 2, 1'b0);
        check("v004_upd", n_upd, 1);
        check("v004_step", n_step, 0);
        check("v004_value", int'(bus.value), 4);

        // upd_cnt saturation
        idle(1'b1);
        tot_upd  = 0;
        tot_step = 0;
        for (int v = 5; v < 260; v++) begin
            drive(pat(v), 2, 1'b0);
            tot_upd  += n_upd;
            tot_step += n_step;
        end
        check("run_upd_total", tot_upd, 255);
        check("run_step_total", tot_step, 0);
        check("cnt_at_255", int'(bus.upd_cnt), 255);
        check("v259_value", int'(bus.value), 259);
        drive(pat(260), 2, 1'b0);
        check("cnt_saturated", int'(bus.upd_cnt), 255);
        drive(pat(300), 2, 1'b1);
        check("clr_evt_step", n_step, 1);
        check("clr_evt_err_step", int'(bus.err_step), 1);
        check("clr_evt_upd_cnt", int'(bus.upd_cnt), 1);

        // Asynchronous reset mid stable run
        drive(pat(301), 1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_value", int'(bus.value), 0);
        check("arst_valid", int'(bus.valid), 0);
        check("arst_flags", int'({bus.err_bad, bus.err_step}), 0);
        check("arst_upd_cnt", int'(bus.upd_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(pat(50), 2, 1'b0);
        check("post_rst_upd", n_upd, 1);
        check("post_rst_step", n_step, 0);
        check("post_rst_valid", int'(bus.valid), 1);
        check("post_rst_value", int'(bus.value), 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_reader_3dig.md
# seg7_reader_3dig

Three-digit seven-segment receiver: samples the active-low segment buses that our counter/display blocks drive, debounces each pattern, and decodes it back to BCD and binary. It sits beside a display driver in the FPGA top level as a self-check monitor. It flags illegal glyphs and any displayed value that is not the previous value plus one, with wrap at MAX_VALUE.

## Interface
Parameters:
- STABLE_N, default 2: consecutive identical samples required before a pattern is accepted (1..15).
- MAX_VALUE, default 999: last count value before wrap to 0 (0..999).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- sample_en  in  1  sample strobe; the segment buses are examined only on cycles where it is 1.
- seg2, seg1, seg0  in  7 each  hundreds/tens/units glyphs, bit order g..a, active-low (0 = lit).
- clear  in  1  synchronous clear of sticky flags and upd_cnt.
- bcd2, bcd1, bcd0  out  4 each  last accepted digits.
- value  out  10  bcd2*100 + bcd1*10 + bcd0.
- valid  out  1  at least one legal pattern accepted since reset.
- upd  out  1  one-cycle pulse on each accepted legal pattern.
- bad_pat  out  1  one-cycle pulse on an accepted illegal pattern.
- step_err  out  1  one-cycle pulse on a sequence violation.
- err_bad, err_step  out  1 each  sticky versions of bad_pat and step_err.
- upd_cnt  out  8  count of upd pulses, saturates at 255.

## Operation
- Glyph decode, per digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other code is illegal.
- Stability filter: 21-bit last_smp plus 4-bit stab_cnt.
  - On a sample_en cycle, if the sample equals last_smp and last_smp is loaded, stab_cnt increments, saturating at STABLE_N. Otherwise last_smp takes the sample and stab_cnt becomes 1.
  - An accept event fires when stab_cnt reaches STABLE_N (its new value equals STABLE_N on this cycle) and the sample differs from acc_pat or acc_pat is not loaded.
  - acc_pat takes the sample on every accept.
  - The same pattern held longer never re-accepts.
- State machine, states EMPTY and LOCKED:
  - EMPTY, after reset: legal accept -> load digits, valid=1, upd; go LOCKED; no sequence check. Illegal accept -> bad_pat, err_bad; stay EMPTY.
  - LOCKED, legal accept:
    - expected = (value == MAX_VALUE) ? 0 : value+1.
    - Load the digits and pulse upd.
    - If new value != expected: step_err pulse and err_step set.
  - LOCKED, illegal accept: bad_pat and err_bad; digits and value hold; the next legal value is checked against the held value.
- Value range: value above MAX_VALUE is still loaded but always raises step_err.
- upd_cnt: +1 per upd, saturates at 255.
- clear: zeroes err_bad, err_step and upd_cnt. An event in the same cycle wins (flag set, upd_cnt = 1). It does not affect value, valid or state.

## Timing
- Reset values: every output 0; state EMPTY; last_smp and acc_pat unloaded.
- Latency: outputs update on the same posedge that captures the STABLE_N-th identical sample.
  - STABLE_N=1: update on the first differing sample's edge.
- Pulses (upd, bad_pat, step_err) are high for exactly one cycle and are registered.
- sample_en low: the filter and outputs freeze; pulses return to 0.
- Reset asserted mid-sequence: all state clears at once; the next legal value is taken without a sequence check.

## Structure
- Package seg7_pkg: ten glyph constants, SEG_BLANK, a digit-width typedef, and a state enum {EMPTY, LOCKED}.
- Sub-module seg7_dec: combinational, 7-bit glyph in, 4-bit BCD plus legal flag out; instantiated three times.
- Top holds the filter, FSM, arithmetic (value as 10-bit sum of shifted terms) and counters.

## Test plan
- Reset, then patterns for 000, 001, 002, each held 3 samples, STABLE_N=2 -> upd three times, value 0,1,2, no errors, upd_cnt=3.
- 999 followed by 000, MAX_VALUE=999 -> no step_err. Then 005 -> step_err pulse, err_step=1, value=5.
- seg0=1111111 (blank) held 2 samples while LOCKED at 7 -> bad_pat, err_bad=1, value stays 7. Then 008 -> no step_err.
- Glitch: 004 for 1 sample, then back to 003 which was already accepted -> no upd. 004 for 2 samples -> upd, value=4.
- upd_cnt at 255 plus one more upd -> stays 255. clear together with step_err -> err_step=1, upd_cnt=1.
- Drop rst in the middle of a stable run -> all outputs 0 asynchronously. After release, 050 -> upd, valid=1, no step_err.
